// File: rtl/syn_m_frame_gen.sv
// syn_m_frame_gen
//   Periodic pulse generator with a 4-byte frame sender behind it.
//   Every cfg_period microseconds (counted on pluse_us) a one-cycle pluse is
//   emitted. If no frame is in flight, that pluse starts a frame:
//     byte0 = 8'hA5, byte1 = id_reg, byte2 = check byte, byte3 = seq.
//   A pluse that arrives while a frame is in flight is dropped and sets the
//   sticky ovr flag. Dropping enable lets the current frame finish, clears
//   the microsecond counter and ovr, and stops new pulses.
//
//   Optional feature macro: SYN_M_CHKSUM_EN
//     defined   : byte2 = 8'hA5 ^ id_reg ^ seq
//     undefined : byte2 = 8'h00 (no XOR logic)
//
// Ports
//   clk_sys    in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   pluse_us   in   1   one-cycle 1 us tick
//   enable     in   1   level, 1 = generate pulses and frames
//   cfg_period in  16   pulse period in us (0 = no pulses)
//   cfg_id     in   8   node id, latched at frame start
//   done_tx    in   1   transmitter accepted the current byte
//   pluse      out  1   one-cycle period pulse
//   fire_tx    out  1   one-cycle byte-send strobe
//   data_tx    out  8   byte to send, held until the next fire_tx
//   busy       out  1   frame in progress
//   ovr        out  1   sticky overrun flag
//
// Byte handshake: fire_tx is a one-cycle strobe with data_tx valid in that
// cycle; data_tx stays stable afterwards. The sender then waits, for as long
// as needed, for a one-cycle done_tx. The next fire_tx follows one cycle after
// that done_tx. done_tx is only looked at while waiting for it.
module syn_m_frame_gen (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic        enable,
  input  logic [15:0] cfg_period,
  input  logic [7:0]  cfg_id,
  input  logic        done_tx,
  output logic        pluse,
  output logic        fire_tx,
  output logic [7:0]  data_tx,
  output logic        busy,
  output logic        ovr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  logic        enable_d;
  logic [15:0] per_reg;
  logic [15:0] cnt_us;
  logic [7:0]  id_reg;
  logic [7:0]  seq;
  logic [1:0]  byte_idx;

  logic        en_rise;
  logic [15:0] per_eff;
  logic [7:0]  byte2;
  logic [7:0]  next_byte;

  assign en_rise = enable & ~enable_d;
  // On the enable rising edge per_reg is only being loaded, so a tick landing
  // in that same cycle must already compare against the new period.
  assign per_eff = en_rise ? cfg_period : per_reg;

`ifdef SYN_M_CHKSUM_EN
  assign byte2 = 8'hA5 ^ id_reg ^ seq;
`else
  assign byte2 = 8'h00;
`endif

  // byte_idx names the byte just accepted; pick the one that follows it.
  always_comb begin
    next_byte = seq;
    case (byte_idx)
      2'd0:    next_byte = id_reg;
      2'd1:    next_byte = byte2;
      default: next_byte = seq;
    endcase
  end

  // Microsecond counter and period pulse.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      enable_d <= 1'b0;
      per_reg  <= 16'd0;
      cnt_us   <= 16'd0;
      pluse    <= 1'b0;
    end else begin
      enable_d <= enable;
      pluse    <= 1'b0;
      if (en_rise || pluse) per_reg <= cfg_period;
      if (!enable) begin
        cnt_us <= 16'd0;
      end else if (pluse_us) begin
        if (per_eff == 16'd0) begin
          cnt_us <= 16'd0;
        end else if (cnt_us == per_eff - 16'd1) begin
          cnt_us <= 16'd0;
          pluse  <= 1'b1;
        end else begin
          cnt_us <= cnt_us + 16'd1;
        end
      end
    end
  end

  // Frame sender: IDLE -> FIRE -> WAIT -> (FIRE | IDLE).
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fire_tx  <= 1'b0;
      data_tx  <= 8'h00;
      busy     <= 1'b0;
      ovr      <= 1'b0;
      id_reg   <= 8'h00;
      seq      <= 8'h00;
      byte_idx <= 2'd0;
    end else begin
      // Overrun: a period pulse found a frame still in flight.
      if (!enable)            ovr <= 1'b0;
      else if (pluse && busy) ovr <= 1'b1;

      case (state)
        IDLE: begin
          if (pluse) begin
            id_reg   <= cfg_id;
            byte_idx <= 2'd0;
            data_tx  <= 8'hA5;
            fire_tx  <= 1'b1;
            busy     <= 1'b1;
            state    <= FIRE;
          end
        end
        FIRE: begin
          fire_tx <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (done_tx) begin
            if (byte_idx == 2'd3) begin
              busy  <= 1'b0;
              seq   <= seq + 8'd1;
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              data_tx  <= next_byte;
              fire_tx  <= 1'b1;
              state    <= FIRE;
            end
          end
        end
        default: begin
          fire_tx <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syn_m_frame_gen.sv
// tb_syn_m_frame_gen
//   Directed bench for syn_m_frame_gen. A background tick source drives
//   pluse_us every 4 clocks, a transmitter model answers each fire_tx with
//   done_tx after done_dly cycles and checks bytes against exp_q, and a pulse
//   monitor checks the number of ticks between period pulses.
module tb_syn_m_frame_gen;

  logic        clk_sys;
  logic        rst_n;
  logic        pluse_us;
  logic        enable;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_id;
  logic        done_tx;
  logic        pluse;
  logic        fire_tx;
  logic [7:0]  data_tx;
  logic        busy;
  logic        ovr;

  int          assert_cnt;
  int          fail_cnt;
  logic [7:0]  exp_q[$];
  int          pushed_cnt;
  int          fire_cnt;
  int          pluse_cnt;
  int          us_since;
  int          exp_period;
  int          done_dly;
  logic        us_run;
  logic [7:0]  last_b2;
  logic [7:0]  last_b3;
  logic [7:0]  exp_seq;

  syn_m_frame_gen dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .pluse_us   (pluse_us),
    .enable     (enable),
    .cfg_period (cfg_period),
    .cfg_id     (cfg_id),
    .done_tx    (done_tx),
    .pluse      (pluse),
    .fire_tx    (fire_tx),
    .data_tx    (data_tx),
    .busy       (busy),
    .ovr        (ovr)
  );

  // Clock / reset
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_chk(input logic [7:0] id, input logic [7:0] sq);
`ifdef SYN_M_CHKSUM_EN
    return 8'hA5 ^ id ^ sq;
`else
    return 8'h00;
`endif
  endfunction

  task automatic push_frame(input logic [7:0] id, input logic [7:0] sq);
    exp_q.push_back(8'hA5);
    exp_q.push_back(id);
    exp_q.push_back(exp_chk(id, sq));
    exp_q.push_back(sq);
    pushed_cnt += 4;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while (i < budget && !(fire_cnt >= target && busy === 1'b0)) begin
      @(negedge clk_sys);
      i++;
    end
    chk(tag, fire_cnt, target);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_fire(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while (i < budget && fire_cnt < target) begin
      @(negedge clk_sys);
      i++;
    end
    chk(tag, fire_cnt, target);
  endtask

  // Driver: 1 us tick every 4 clocks
  initial begin
    int us_div;
    us_div   = 0;
    pluse_us = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (us_run && us_div == 3) begin
        pluse_us = 1'b1;
        us_div   = 0;
      end else begin
        pluse_us = 1'b0;
        if (us_run) us_div++;
      end
    end
  end

  // Pulse monitor: ticks counted at the edge the DUT samples them
  initial begin
    us_since  = 0;
    pluse_cnt = 0;
    forever begin
      @(posedge clk_sys);
      if (!rst_n || !enable) us_since = 0;
      else if (pluse_us)     us_since++;
      @(negedge clk_sys);
      if (rst_n && pluse) begin
        pluse_cnt++;
        chk("pluse_period", us_since, exp_period);
        us_since = 0;
      end
    end
  end

  // Transmitter model and scoreboard
  initial begin
    int   tx_cnt;
    int   byte_pos;
    logic fire_prev;
    logic [7:0] exp_b;
    done_tx   = 1'b0;
    tx_cnt    = 0;
    byte_pos  = 0;
    fire_prev = 1'b0;
    fire_cnt  = 0;
    forever begin
      @(negedge clk_sys);
      done_tx = 1'b0;
      if (!rst_n) begin
        tx_cnt    = 0;
        byte_pos  = 0;
        fire_prev = 1'b0;
      end else begin
        if (fire_prev) chk("fire_one_cycle", fire_tx, 0);
        fire_prev = fire_tx;
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) done_tx = 1'b1;
        end
        if (fire_tx) begin
          fire_cnt++;
          chk("fire_allowed", fire_cnt <= pushed_cnt, 1);
          chk("busy_at_fire", busy, 1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            chk("data_tx", data_tx, exp_b);
          end
          if (byte_pos == 2) last_b2 = data_tx;
          if (byte_pos == 3) last_b3 = data_tx;
          byte_pos = (byte_pos + 1) % 4;
          tx_cnt   = done_dly - 1;
        end
      end
    end
  end

  // Directed sequence
  initial begin
    int base;
    int p0;
    int f0;
    assert_cnt = 0;
    fail_cnt   = 0;
    pushed_cnt = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    cfg_period = 16'd0;
    cfg_id     = 8'h00;
    us_run     = 1'b0;
    exp_period = 0;
    done_dly   = 3;
    last_b2    = 8'h00;
    last_b3    = 8'h00;
    exp_seq    = 8'h00;

    repeat (3) @(negedge clk_sys);
    chk("rst_pluse",   pluse,   0);
    chk("rst_fire_tx", fire_tx, 0);
    chk("rst_data_tx", data_tx, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_ovr",     ovr,     0);
    rst_n  = 1'b1;
    us_run = 1'b1;

    // Period 5, done after 3 cycles; run through seq 07 and the FF->00 wrap
    cfg_period = 16'd5;
    cfg_id     = 8'h3C;
    exp_period = 5;
    repeat (2) @(negedge clk_sys);
    enable = 1'b1;
    for (int f = 0; f < 257; f++) begin
      if (f >= 16) cfg_id = 8'($urandom_range(0, 255));
      push_frame(cfg_id, exp_seq);
      wait_done(fire_cnt + 4, 200, "frame_done");
      chk("pluse_count", pluse_cnt, f + 1);
      if (exp_seq == 8'h07) chk("byte2_id3c_seq07", last_b2, exp_chk(8'h3C, 8'h07));
      if (exp_seq == 8'hFF) chk("byte3_seq_ff", last_b3, 8'hFF);
      if (f == 256)         chk("byte3_seq_wrap", last_b3, 8'h00);
      exp_seq = exp_seq + 8'd1;
    end
    enable = 1'b0;
    repeat (5) @(negedge clk_sys);
    chk("ovr_clear_before_overrun", ovr, 0);

    // Overrun: period 2 us with done_tx 10 us after each fire
    cfg_period = 16'd2;
    exp_period = 2;
    done_dly   = 40;
    enable     = 1'b1;
    base       = fire_cnt;
    push_frame(cfg_id, exp_seq);
    wait_done(base + 4, 600, "ovr_frame1");
    chk("ovr_set", ovr, 1);
    exp_seq = exp_seq + 8'd1;
    push_frame(cfg_id, exp_seq);
    wait_fire(base + 5, 100, "ovr_frame2_start");
    enable = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("ovr_cleared_on_disable", ovr, 0);
    chk("busy_after_disable", busy, 1);
    wait_done(base + 8, 600, "ovr_frame2");
    exp_seq = exp_seq + 8'd1;
    p0 = pluse_cnt;
    f0 = fire_cnt;
    repeat (80) @(negedge clk_sys);
    chk("no_pluse_disabled", pluse_cnt, p0);
    chk("no_fire_disabled",  fire_cnt,  f0);

    // Period 0: nothing for 100 us
    cfg_period = 16'd0;
    exp_period = 0;
    done_dly   = 3;
    enable     = 1'b1;
    p0 = pluse_cnt;
    f0 = fire_cnt;
    repeat (400) @(negedge clk_sys);
    chk("period0_no_pluse", pluse_cnt, p0);
    chk("period0_no_fire",  fire_cnt,  f0);
    enable = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Reset in the middle of a frame, after byte 1 went out
    cfg_period = 16'd5;
    exp_period = 5;
    cfg_id     = 8'h5A;
    repeat (2) @(negedge clk_sys);
    enable = 1'b1;
    base   = fire_cnt;
    push_frame(cfg_id, exp_seq);
    wait_fire(base + 2, 200, "pre_reset_byte1");
    rst_n = 1'b0;
    #1;
    chk("midrst_pluse",   pluse,   0);
    chk("midrst_fire_tx", fire_tx, 0);
    chk("midrst_data_tx", data_tx, 0);
    chk("midrst_busy",    busy,    0);
    chk("midrst_ovr",     ovr,     0);
    exp_q.delete();
    pushed_cnt = fire_cnt;
    repeat (10) @(negedge clk_sys);
    rst_n   = 1'b1;
    exp_seq = 8'h00;
    base    = fire_cnt;
    push_frame(cfg_id, exp_seq);
    wait_done(base + 4, 200, "post_reset_frame");
    chk("post_reset_seq", last_b3, 8'h00);
    enable = 1'b0;
    repeat (5) @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
